mem_port_arbiter: RTL and testbench

- Shares one single-ported instruction/data RAM between the CPU instruction-fetch path (PC side) and the load/store data path (ALU address, store data, load data).
- Arbitrates between the two requesters with round-robin priority.
- Sequences a fixed-latency memory access and routes the read data back to the winner.
- Generates a stall for the CPU while either path is waiting. It sits between the CPU core and the RAM.

---
 rtl/mem_port_arbiter_if.sv | 40 ++++
 rtl/mem_port_arbiter.sv | 105 ++++++++++
 tb/tb_mem_port_arbiter.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the CPU fetch/data paths, the memory port arbiter and the RAM.
// The arbiter connects through the slave modport; the CPU/RAM side uses master.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              cpu_stall;

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, cpu_stall
    );

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, cpu_stall
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-ported RAM between instruction fetch and
// load/store, with fixed-latency sequencing, read-data routing and CPU stall.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic              clock,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);
    localparam int unsigned      CNT_W    = 4;
    localparam logic [CNT_W-1:0] LAT_CNT  = CNT_W'(MEM_LAT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

    typedef enum logic { FREE = 1'b0, BUSY = 1'b1 } state_t;
    typedef enum logic { OWN_IF = 1'b0, OWN_D = 1'b1 } owner_t;

    state_t            state, state_nxt;
    owner_t            owner, owner_nxt;
    owner_t            last_owner, last_owner_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [ADDR_W-1:0] addr_q, addr_nxt;
    logic [DATA_W-1:0] wdata_q, wdata_nxt;
    logic              done;
    logic              slot;
    logic              grant_if;
    logic              grant_d;
    logic              if_rvalid;
    logic              d_rvalid;

    // State register; addr_q/wdata_q keep the RAM address/data stable between grants.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= FREE;
            owner      <= OWN_D;
            last_owner <= OWN_D;
            cnt        <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            last_owner <= last_owner_nxt;
            cnt        <= cnt_nxt;
            addr_q     <= addr_nxt;
            wdata_q    <= wdata_nxt;
        end
    end

    // Grant slots open when idle or in the completion cycle, giving back-to-back issue.
    always_comb begin
        state_nxt      = state;
        owner_nxt      = owner;
        last_owner_nxt = last_owner;
        cnt_nxt        = cnt;
        addr_nxt       = addr_q;
        wdata_nxt      = wdata_q;
        grant_if       = 1'b0;
        grant_d        = 1'b0;

        done = !reset && (state == BUSY) && (cnt == CNT_LAST);
        slot = !reset && ((state == FREE) || done);

        if (slot) begin
            if (bus.if_req && (!bus.d_req || (last_owner == OWN_D))) begin
                grant_if = 1'b1;
            end else if (bus.d_req) begin
                grant_d = 1'b1;
            end
        end

        if (state == BUSY) begin
            cnt_nxt = cnt - CNT_LAST;
            if (cnt == CNT_LAST) begin
                state_nxt = FREE;
            end
        end

        if (grant_if || grant_d) begin
            state_nxt      = BUSY;
            cnt_nxt        = LAT_CNT;
            owner_nxt      = grant_d ? OWN_D : OWN_IF;
            last_owner_nxt = grant_d ? OWN_D : OWN_IF;
            addr_nxt       = grant_d ? bus.d_addr : bus.if_addr;
            wdata_nxt      = grant_d ? bus.d_wdata : '0;
        end

        if_rvalid = done && (owner == OWN_IF);
        d_rvalid  = done && (owner == OWN_D);

        bus.if_gnt    = grant_if;
        bus.d_gnt     = grant_d;
        bus.if_rvalid = if_rvalid;
        bus.d_rvalid  = d_rvalid;
        bus.if_rdata  = bus.mem_rdata;
        bus.d_rdata   = bus.mem_rdata;
        bus.mem_en    = grant_if || grant_d;
        bus.mem_we    = grant_d && bus.d_we;
        bus.mem_addr  = addr_nxt;
        bus.mem_wdata = wdata_nxt;
        bus.cpu_stall = (bus.if_req && !if_rvalid) || (bus.d_req && !d_rvalid)
                        || ((state == BUSY) && (cnt != CNT_LAST));
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: two instances (MEM_LAT 1 and 3) against a
// cycle-number based reference model with a behavioural RAM.
module tb_mem_port_arbiter;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned WORDS  = 256;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    logic              sel      = 1'b0;
    logic              ram_init = 1'b1;
    logic              if_req   = 1'b0;
    logic [ADDR_W-1:0] if_addr  = '0;
    logic              d_req    = 1'b0;
    logic              d_we     = 1'b0;
    logic [ADDR_W-1:0] d_addr   = '0;
    logic [DATA_W-1:0] d_wdata  = '0;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus1 ();
    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus3 ();

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(1)) dut1 (
        .clock(clock), .reset(reset), .bus(bus1.slave));
    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(3)) dut3 (
        .clock(clock), .reset(reset), .bus(bus3.slave));

    // Only the selected instance sees requests; the other stays idle.
    assign bus1.if_req  = if_req && !sel;
    assign bus1.d_req   = d_req && !sel;
    assign bus3.if_req  = if_req && sel;
    assign bus3.d_req   = d_req && sel;
    assign bus1.if_addr = if_addr;
    assign bus3.if_addr = if_addr;
    assign bus1.d_we    = d_we;
    assign bus3.d_we    = d_we;
    assign bus1.d_addr  = d_addr;
    assign bus3.d_addr  = d_addr;
    assign bus1.d_wdata = d_wdata;
    assign bus3.d_wdata = d_wdata;

    logic              o_if_gnt, o_d_gnt, o_if_rvalid, o_d_rvalid;
    logic              o_mem_en, o_mem_we, o_stall;
    logic [DATA_W-1:0] o_if_rdata, o_d_rdata, o_mem_wdata;
    logic [ADDR_W-1:0] o_mem_addr;
    assign o_if_gnt    = sel ? bus3.if_gnt    : bus1.if_gnt;
    assign o_d_gnt     = sel ? bus3.d_gnt     : bus1.d_gnt;
    assign o_if_rvalid = sel ? bus3.if_rvalid : bus1.if_rvalid;
    assign o_d_rvalid  = sel ? bus3.d_rvalid  : bus1.d_rvalid;
    assign o_if_rdata  = sel ? bus3.if_rdata  : bus1.if_rdata;
    assign o_d_rdata   = sel ? bus3.d_rdata   : bus1.d_rdata;
    assign o_mem_en    = sel ? bus3.mem_en    : bus1.mem_en;
    assign o_mem_we    = sel ? bus3.mem_we    : bus1.mem_we;
    assign o_mem_addr  = sel ? bus3.mem_addr  : bus1.mem_addr;
    assign o_mem_wdata = sel ? bus3.mem_wdata : bus1.mem_wdata;
    assign o_stall     = sel ? bus3.cpu_stall : bus1.cpu_stall;

    function automatic logic [DATA_W-1:0] init_word(input int i);
        return (i == 64) ? 32'hDEAD_BEEF : DATA_W'(32'hA5C3_0000 + 32'(i * 7));
    endfunction

    function automatic int widx(input logic [ADDR_W-1:0] a);
        return int'(a[9:2]);
    endfunction

    function automatic logic [ADDR_W-1:0] raddr();
        logic [7:0] w;
        w = 8'($urandom_range(0, 255));
        return ADDR_W'({w, 2'b00});
    endfunction

    // Behavioural RAM: read data appears on pipe[n-1] n cycles after the strobe.
    logic [DATA_W-1:0] ram  [WORDS];
    logic [DATA_W-1:0] pipe [8];
    always @(posedge clock) begin
        for (int i = 7; i > 0; i--) pipe[i] <= pipe[i-1];
        pipe[0] <= 32'hBAAD_F00D;
        if (ram_init) begin
            for (int i = 0; i < int'(WORDS); i++) ram[i] <= init_word(i);
        end else if (o_mem_en) begin
            pipe[0] <= ram[widx(o_mem_addr)];
            if (o_mem_we) ram[widx(o_mem_addr)] <= o_mem_wdata;
        end
    end
    assign bus1.mem_rdata = pipe[0];
    assign bus3.mem_rdata = pipe[2];

    // Reference model: slots and completions tracked as absolute cycle numbers.
    logic [DATA_W-1:0] ref_mem [WORDS];
    int                lat, cyc, busy_until, pend_due;
    bit                pend_valid, pend_d, pend_load, last_d;
    logic [DATA_W-1:0] pend_data, held_wdata, e_mem_wdata, e_rdata;
    logic [ADDR_W-1:0] held_addr, e_mem_addr;
    bit                e_if_gnt, e_d_gnt, e_mem_en, e_mem_we;
    bit                e_if_rvalid, e_d_rvalid, e_stall, e_chk, e_done;

    task automatic model_reset(input logic s);
        lat = s ? 3 : 1;
        cyc = 0;
        busy_until = 0;
        pend_valid = 1'b0;
        last_d = 1'b1;
        held_addr = '0;
        held_wdata = '0;
    endtask

    task automatic model_predict();
        e_if_gnt = 1'b0;
        e_d_gnt  = 1'b0;
        if (cyc >= busy_until) begin
            if (if_req && d_req) begin
                if (last_d) e_if_gnt = 1'b1; else e_d_gnt = 1'b1;
            end else if (if_req) e_if_gnt = 1'b1;
            else if (d_req) e_d_gnt = 1'b1;
        end
        e_mem_en    = e_if_gnt || e_d_gnt;
        e_mem_we    = e_d_gnt && d_we;
        e_mem_addr  = e_if_gnt ? if_addr : (e_d_gnt ? d_addr : held_addr);
        e_mem_wdata = e_if_gnt ? '0 : (e_d_gnt ? d_wdata : held_wdata);
        e_done      = pend_valid && (pend_due == cyc);
        e_if_rvalid = e_done && !pend_d;
        e_d_rvalid  = e_done && pend_d;
        e_chk       = e_done && pend_load;
        e_rdata     = pend_data;
        e_stall     = (if_req && !e_if_rvalid) || (d_req && !e_d_rvalid)
                      || (pend_valid && (cyc < pend_due));
    endtask

    task automatic model_commit();
        if (e_done) pend_valid = 1'b0;
        if (e_mem_en) begin
            pend_valid = 1'b1;
            pend_d     = e_d_gnt;
            pend_due   = cyc + lat;
            busy_until = cyc + lat;
            last_d     = e_d_gnt;
            pend_load  = !e_mem_we;
            pend_data  = ref_mem[widx(e_mem_addr)];
            if (e_mem_we) ref_mem[widx(e_mem_addr)] = e_mem_wdata;
            held_addr  = e_mem_addr;
            held_wdata = e_mem_wdata;
        end
        cyc++;
    endtask

    task automatic do_reset(input logic s);
        if_req = 1'b0;
        d_req  = 1'b0;
        d_we   = 1'b0;
        reset  = 1'b1;
        sel    = s;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset(s);
    endtask

    task automatic test_reset();
        logic [6:0] ctl;
        for (int s = 0; s < 2; s++) begin
            do_reset(1'(s));
            @(negedge clock);
            ctl = {o_if_gnt, o_d_gnt, o_if_rvalid, o_d_rvalid, o_mem_en, o_mem_we, o_stall};
            n_checks++;
            if (ctl !== 7'b0) begin n_fail++; $display("FAIL reset_ctl lat%0d: got %b want 0000000", s*2+1, ctl); end
            n_checks++;
            if ({o_mem_addr, o_mem_wdata} !== 64'h0) begin
                n_fail++; $display("FAIL reset_bus lat%0d: got addr %h wdata %h want 0", s*2+1, o_mem_addr, o_mem_wdata);
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_fetch_stream();
        int n;
        bit g;
        n = 0;
        do_reset(1'b0);
        if_req = 1'b1;
        if_addr = 32'h0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            model_predict();
            n_checks++;
            if (o_if_gnt !== e_if_gnt) begin n_fail++; $display("FAIL fetch_gnt k%0d: got %b want %b", k, o_if_gnt, e_if_gnt); end
            n_checks++;
            if (o_mem_addr !== e_mem_addr) begin n_fail++; $display("FAIL fetch_addr k%0d: got %h want %h", k, o_mem_addr, e_mem_addr); end
            n_checks++;
            if (o_if_rvalid !== e_if_rvalid) begin n_fail++; $display("FAIL fetch_rvalid k%0d: got %b want %b", k, o_if_rvalid, e_if_rvalid); end
            if (e_chk) begin
                n_checks++;
                if (o_if_rdata !== e_rdata) begin n_fail++; $display("FAIL fetch_rdata k%0d: got %h want %h", k, o_if_rdata, e_rdata); end
            end
            n_checks++;
            if (o_stall !== e_stall) begin n_fail++; $display("FAIL fetch_stall k%0d: got %b want %b", k, o_stall, e_stall); end
            g = o_if_gnt;
            model_commit();
            @(posedge clock); #1;
            if (g) begin
                n++;
                if (n < 3) if_addr = ADDR_W'(n * 4); else if_req = 1'b0;
            end
        end
    endtask

    task automatic test_alternate();
        bit ig, dg;
        do_reset(1'b0);
        if_req = 1'b1; if_addr = raddr();
        d_req = 1'b1; d_we = 1'b0; d_addr = raddr();
        for (int k = 0; k < 7; k++) begin
            @(negedge clock);
            model_predict();
            if (k < 6) begin
                n_checks++;
                if ({o_if_gnt, o_d_gnt} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
                    n_fail++; $display("FAIL alt_order k%0d: got if/d %b%b want %s", k, o_if_gnt, o_d_gnt, (k % 2 == 0) ? "IF" : "D");
                end
            end
            n_checks++;
            if ({o_if_rvalid, o_d_rvalid} !== {e_if_rvalid, e_d_rvalid}) begin
                n_fail++; $display("FAIL alt_rvalid k%0d: got %b%b want %b%b", k, o_if_rvalid, o_d_rvalid, e_if_rvalid, e_d_rvalid);
            end
            if (e_chk) begin
                n_checks++;
                if ((pend_d ? o_d_rdata : o_if_rdata) !== e_rdata) begin
                    n_fail++; $display("FAIL alt_rdata k%0d: got %h want %h", k, pend_d ? o_d_rdata : o_if_rdata, e_rdata);
                end
            end
            ig = o_if_gnt; dg = o_d_gnt;
            model_commit();
            @(posedge clock); #1;
            if (ig) if_addr = raddr();
            if (dg) d_addr = raddr();
            if (k == 5) begin if_req = 1'b0; d_req = 1'b0; end
        end
    endtask

    task automatic test_idle();
        do_reset(1'b0);
        if_req = 1'b1; if_addr = 32'h24;
        for (int k = 0; k < 9; k++) begin
            @(negedge clock);
            model_predict();
            if (k >= 2 && k <= 6) begin
                n_checks++;
                if ({o_if_gnt, o_d_gnt, o_mem_en, o_mem_we, o_stall} !== 5'b0) begin
                    n_fail++; $display("FAIL idle_ctl k%0d: got gnt %b%b en %b we %b stall %b want 0", k, o_if_gnt, o_d_gnt, o_mem_en, o_mem_we, o_stall);
                end
                n_checks++;
                if (o_mem_addr !== 32'h24) begin n_fail++; $display("FAIL idle_addr_hold k%0d: got %h want 00000024", k, o_mem_addr); end
            end
            if (k == 0 || k == 7) begin
                n_checks++;
                if (o_if_gnt !== 1'b1) begin n_fail++; $display("FAIL idle_grant k%0d: got %b want 1", k, o_if_gnt); end
            end
            if (e_chk) begin
                n_checks++;
                if (o_if_rdata !== e_rdata) begin n_fail++; $display("FAIL idle_rdata k%0d: got %h want %h", k, o_if_rdata, e_rdata); end
            end
            model_commit();
            @(posedge clock); #1;
            if (k == 0 || k == 7) if_req = 1'b0;
            if (k == 6) begin if_req = 1'b1; if_addr = 32'h28; end
        end
    endtask

    task automatic test_load_lat3();
        do_reset(1'b1);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            model_predict();
            n_checks++;
            if (o_d_gnt !== (k == 0)) begin n_fail++; $display("FAIL lat3_gnt k%0d: got %b want %b", k, o_d_gnt, k == 0); end
            n_checks++;
            if (o_d_rvalid !== (k == 3)) begin n_fail++; $display("FAIL lat3_rvalid k%0d: got %b want %b", k, o_d_rvalid, k == 3); end
            n_checks++;
            if (o_stall !== (k < 3)) begin n_fail++; $display("FAIL lat3_stall k%0d: got %b want %b", k, o_stall, k < 3); end
            if (k == 3) begin
                n_checks++;
                if (o_d_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL lat3_rdata: got %h want deadbeef", o_d_rdata); end
            end
            model_commit();
            @(posedge clock); #1;
            if (k == 0) d_req = 1'b0;
        end
    endtask

    task automatic test_store_load();
        int phase, we_cycles;
        bit fin, g;
        phase = 0; we_cycles = 0; fin = 1'b0;
        do_reset(1'b1);
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h1234_5678;
        for (int k = 0; k < 20 && !fin; k++) begin
            @(negedge clock);
            model_predict();
            n_checks++;
            if (o_mem_we !== e_mem_we) begin n_fail++; $display("FAIL st_mem_we k%0d: got %b want %b", k, o_mem_we, e_mem_we); end
            n_checks++;
            if (o_d_gnt !== e_d_gnt) begin n_fail++; $display("FAIL st_gnt k%0d: got %b want %b", k, o_d_gnt, e_d_gnt); end
            n_checks++;
            if (o_d_rvalid !== e_d_rvalid) begin n_fail++; $display("FAIL st_rvalid k%0d: got %b want %b", k, o_d_rvalid, e_d_rvalid); end
            if (o_mem_we) we_cycles++;
            if (phase == 2 && e_d_rvalid) begin
                n_checks++;
                if (o_d_rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL st_load_data: got %h want 12345678", o_d_rdata); end
                fin = 1'b1;
            end
            g = o_d_gnt;
            model_commit();
            @(posedge clock); #1;
            if (g && phase == 0) begin d_we = 1'b0; phase = 1; end
            else if (g && phase == 1) begin d_req = 1'b0; phase = 2; end
        end
        n_checks++;
        if (!fin) begin n_fail++; $display("FAIL st_timeout: got phase %0d want load completed", phase); end
        n_checks++;
        if (we_cycles != 1) begin n_fail++; $display("FAIL st_we_count: got %0d want 1", we_cycles); end
        d_req = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset(1'b1);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
        @(negedge clock);
        n_checks++;
        if (o_d_gnt !== 1'b1) begin n_fail++; $display("FAIL rmid_gnt: got %b want 1", o_d_gnt); end
        @(posedge clock); #1;
        d_req = 1'b0; reset = 1'b1;
        @(negedge clock);
        n_checks++;
        if (o_d_rvalid !== 1'b0) begin n_fail++; $display("FAIL rmid_rvalid_in_reset: got %b want 0", o_d_rvalid); end
        @(posedge clock); #1;
        reset = 1'b0;
        model_reset(1'b1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            model_predict();
            n_checks++;
            if ({o_if_gnt, o_d_gnt, o_if_rvalid, o_d_rvalid, o_mem_en, o_mem_we, o_stall} !== 7'b0) begin
                n_fail++; $display("FAIL rmid_ctl k%0d: got rvalid %b en %b stall %b want 0", k, o_d_rvalid, o_mem_en, o_stall);
            end
            n_checks++;
            if ({o_mem_addr, o_mem_wdata} !== 64'h0) begin n_fail++; $display("FAIL rmid_bus k%0d: got %h %h want 0", k, o_mem_addr, o_mem_wdata); end
            model_commit();
            @(posedge clock); #1;
        end
        d_req = 1'b1; d_addr = 32'h8;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            model_predict();
            n_checks++;
            if ({o_d_gnt, o_d_rvalid} !== {k == 0, k == 3}) begin
                n_fail++; $display("FAIL rmid_next k%0d: got gnt %b rvalid %b want %b %b", k, o_d_gnt, o_d_rvalid, k == 0, k == 3);
            end
            if (e_chk) begin
                n_checks++;
                if (o_d_rdata !== e_rdata) begin n_fail++; $display("FAIL rmid_rdata: got %h want %h", o_d_rdata, e_rdata); end
            end
            model_commit();
            @(posedge clock); #1;
            if (k == 0) d_req = 1'b0;
        end
    endtask

    task automatic test_random(input logic s);
        bit ig, dg;
        do_reset(s);
        for (int k = 0; k < 400; k++) begin
            @(negedge clock);
            model_predict();
            n_checks++;
            if ({o_if_gnt, o_d_gnt} !== {e_if_gnt, e_d_gnt}) begin
                n_fail++; $display("FAIL rnd_gnt lat%0d k%0d: got %b%b want %b%b", lat, k, o_if_gnt, o_d_gnt, e_if_gnt, e_d_gnt);
            end
            n_checks++;
            if (o_if_gnt && o_d_gnt) begin n_fail++; $display("FAIL rnd_dual_gnt lat%0d k%0d: got both want at most one", lat, k); end
            n_checks++;
            if ({o_mem_en, o_mem_we} !== {e_mem_en, e_mem_we}) begin
                n_fail++; $display("FAIL rnd_en_we lat%0d k%0d: got %b%b want %b%b", lat, k, o_mem_en, o_mem_we, e_mem_en, e_mem_we);
            end
            n_checks++;
            if (o_mem_addr !== e_mem_addr) begin n_fail++; $display("FAIL rnd_addr lat%0d k%0d: got %h want %h", lat, k, o_mem_addr, e_mem_addr); end
            n_checks++;
            if (o_mem_wdata !== e_mem_wdata) begin n_fail++; $display("FAIL rnd_wdata lat%0d k%0d: got %h want %h", lat, k, o_mem_wdata, e_mem_wdata); end
            n_checks++;
            if ({o_if_rvalid, o_d_rvalid} !== {e_if_rvalid, e_d_rvalid}) begin
                n_fail++; $display("FAIL rnd_rvalid lat%0d k%0d: got %b%b want %b%b", lat, k, o_if_rvalid, o_d_rvalid, e_if_rvalid, e_d_rvalid);
            end
            if (e_chk) begin
                n_checks++;
                if ((pend_d ? o_d_rdata : o_if_rdata) !== e_rdata) begin
                    n_fail++; $display("FAIL rnd_rdata lat%0d k%0d: got %h want %h", lat, k, pend_d ? o_d_rdata : o_if_rdata, e_rdata);
                end
            end
            n_checks++;
            if (o_stall !== e_stall) begin n_fail++; $display("FAIL rnd_stall lat%0d k%0d: got %b want %b", lat, k, o_stall, e_stall); end
            ig = o_if_gnt; dg = o_d_gnt;
            model_commit();
            @(posedge clock); #1;
            if (ig || !if_req) begin
                if_req = ($urandom_range(0, 2) != 0);
                if_addr = raddr();
            end else if ($urandom_range(0, 15) == 0) if_req = 1'b0;
            if (dg || !d_req) begin
                d_req = ($urandom_range(0, 2) != 0);
                d_we = ($urandom_range(0, 1) != 0);
                d_addr = raddr();
                d_wdata = $urandom;
            end else if ($urandom_range(0, 15) == 0) d_req = 1'b0;
        end
        if_req = 1'b0;
        d_req = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < int'(WORDS); i++) ref_mem[i] = init_word(i);
        @(posedge clock); #1;
        ram_init = 1'b0;
        test_reset();
        test_fetch_stream();
        test_alternate();
        test_idle();
        test_load_lat3();
        test_store_load();
        test_reset_mid();
        test_random(1'b0);
        test_random(1'b1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test want completion within time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
